// File: rtl/bp_pkg.sv
// Shared constants, entry layout and counter helpers for the IF-stage
// branch target buffer.
package bp_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int ENTRIES_DEF = 64;
  localparam int CNT_W_DEF   = 2;
  localparam int IDX_W_DEF   = $clog2(ENTRIES_DEF);
  localparam int TAG_W_DEF   = XLEN_DEF - IDX_W_DEF - 2;

  // Layout of one BTB entry in the default configuration. The top keeps the
  // same fields in per-field arrays sized by its own parameters, so that the
  // valid bits can be reset without resetting the payload.
  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [XLEN_DEF-1:0]   target;
    logic                  is_jump;
    logic [CNT_W_DEF-1:0]  ctr;
  } bp_entry_t;

  // Saturation ceiling of a cnt_w-bit direction counter.
  function automatic int ctr_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  // Value of a freshly allocated entry: the weakest "taken" state.
  function automatic int ctr_weak_t(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

endpackage : bp_pkg

// File: rtl/bp_sat_counter.sv
// Next-state logic of one up/down saturating direction counter.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] ctr,
  input  logic             up,
  output logic [CNT_W-1:0] ctr_nxt
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(ctr_max(CNT_W));

  // NOTE: ctr_nxt gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    ctr_nxt = ctr;
    if (up) begin
      if (ctr != MAX) ctr_nxt = ctr + CNT_W'(1);
    end else begin
      if (ctr != '0) ctr_nxt = ctr - CNT_W'(1);
    end
  end

endmodule : bp_sat_counter

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational lookup on pc_if, registered training from the ID stage.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [XLEN-1:0]   pc_if,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispred,
  output logic [PERF_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] WEAK_T = CNT_W'(ctr_weak_t(CNT_W));

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CNT_W-1:0]   ctr_q    [ENTRIES];
  logic [CNT_W-1:0]   ctr_nxt  [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             upd_en, alloc;
  logic [3:0]       unused_lsbs;

  // Instructions are word aligned; the two low PC bits carry no information.
  assign unused_lsbs = {pc_if[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  assign lk_idx = pc_if[IDX_W+1:2];
  assign lk_tag = pc_if[XLEN-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][CNT_W-1]);
  assign pred_target = pred_taken ? target_q[lk_idx] : pc_if + XLEN'(4);

  // ---------------------------------------------------------------- update
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // A simultaneous clear wins: the resolved instruction is simply not learnt.
  assign upd_en = upd_valid && !clear;
  assign alloc  = upd_en && !up_hit && upd_taken;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bp_sat_counter #(
      .CNT_W (CNT_W)
    ) u_ctr (
      .ctr     (ctr_q[i]),
      .up      (upd_taken),
      .ctr_nxt (ctr_nxt[i])
    );
  end

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; a lookup in the update cycle sees the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // NOTE: the table payload is deliberately left out of reset; nothing reads
  // it while the matching valid bit is 0, so clearing it would only add
  // reset fan-out to a few thousand flops.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_nxt[up_idx];
        if (upd_taken) begin
          target_q[up_idx] <= upd_target;
          jump_q[up_idx]   <= upd_is_jump;
        end
      end else if (upd_taken) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        jump_q[up_idx]   <= upd_is_jump;
        ctr_q[up_idx]    <= WEAK_T;
      end
    end
  end

  // ---------------------------------------------------- mispredict counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispred_count <= '0;
    end else if (upd_valid && upd_mispred && (mispred_count != '1)) begin
      mispred_count <= mispred_count + PERF_W'(1);
    end
  end

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed table, multi-cycle
// corner sequences, then random traffic against an array-based model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] pc_if = 32'h0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_mispred = 1'b0;

  logic        pred_taken, p4_taken;
  logic [31:0] pred_target, p4_target;
  logic [31:0] mispred_count;
  logic [3:0]  p4_count;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .CNT_W(2), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .clear(clear), .pc_if(pc_if),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred),
    .mispred_count(mispred_count)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(64), .CNT_W(2), .PERF_W(4)) dut_p4 (
    .clk(clk), .rst(rst), .clear(clear), .pc_if(pc_if),
    .pred_taken(p4_taken), .pred_target(p4_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred),
    .mispred_count(p4_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------ reference model
  // A 64-slot direct-mapped table addressed by word number; counters are
  // plain integers clamped to 0..3.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int unsigned m_tgt   [64];
  bit          m_jump  [64];
  int          m_ctr   [64];
  longint      m_cnt32;
  int          m_cnt4;

  function automatic int unsigned idx_of(input int unsigned pc);
    return (pc / 4) % 64;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / 256;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_cnt32 = 0;
    m_cnt4  = 0;
  endtask

  task automatic model_predict(input int unsigned pc, output bit tk, output int unsigned tg);
    int unsigned i;
    bit hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    tk  = hit && (m_jump[i] || m_ctr[i] >= 2);
    tg  = tk ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_update();
    int unsigned i;
    bit hit;
    if (!rst) return;
    if (clear) begin
      for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
    end else if (upd_valid) begin
      i   = idx_of(upd_pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
      if (hit && upd_taken) begin
        m_ctr[i]  = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i]  = upd_target;
        m_jump[i] = upd_is_jump;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(upd_pc);
        m_tgt[i]   = upd_target;
        m_jump[i]  = upd_is_jump;
        m_ctr[i]   = 2;
      end
    end
    if (upd_valid && upd_mispred) begin
      if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  // ------------------------------------------------------------- stimulus
  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        uj;
    logic        ut;
    logic [31:0] utgt;
    logic        um;
    logic        clr;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [31:0] pc, input logic uv,
                              input logic [31:0] upc, input logic uj, input logic ut,
                              input logic [31:0] utgt, input logic um, input logic clr,
                              input logic et, input logic [31:0] etgt);
    vec_t v;
    v.name = nm; v.pc = pc; v.uv = uv; v.upc = upc; v.uj = uj; v.ut = ut;
    v.utgt = utgt; v.um = um; v.clr = clr; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  function automatic vec_t idle(input string nm, input logic [31:0] pc,
                                input logic et, input logic [31:0] etgt);
    return mk(nm, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, et, etgt);
  endfunction

  // Inputs change on the falling edge; outputs are sampled 2 ns later.
  task automatic apply(input vec_t v);
    @(negedge clk);
    pc_if = v.pc; upd_valid = v.uv; upd_pc = v.upc; upd_is_jump = v.uj;
    upd_taken = v.ut; upd_target = v.utgt; upd_mispred = v.um; clear = v.clr;
    #2;
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt32"}, mispred_count, m_cnt32);
    check({tag, "_cnt4"}, p4_count, m_cnt4);
  endtask

  function automatic logic [31:0] rand_pc();
    return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
  endfunction

  vec_t        tbl[$];
  vec_t        v;
  bit          m_tk;
  int unsigned m_tg;

  initial begin
    // Reset state, observed while rst is still asserted.
    model_reset();
    pc_if = 32'h100;
    #12;
    check("rst_taken", pred_taken, 1'b0);
    check("rst_target", pred_target, 32'h104);
    check("rst_cnt", mispred_count, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table: expected values are the same-cycle (pre-update) lookup.
    tbl.push_back(idle("r_idle", 32'h100, 0, 32'h104));
    tbl.push_back(mk("alloc", 32'h100, 1, 32'h100, 0, 1, 32'h40, 1, 0, 0, 32'h104));
    tbl.push_back(idle("alloc_hit", 32'h100, 1, 32'h40));
    tbl.push_back(idle("lsb_ignored", 32'h103, 1, 32'h40));
    tbl.push_back(mk("nt1", 32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 1, 32'h40));
    tbl.push_back(mk("nt2", 32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 0, 32'h104));
    tbl.push_back(mk("nt_floor", 32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 0, 32'h104));
    tbl.push_back(mk("t_from0", 32'h100, 1, 32'h100, 0, 1, 32'h40, 0, 0, 0, 32'h104));
    tbl.push_back(mk("t_from1", 32'h100, 1, 32'h100, 0, 1, 32'h40, 0, 0, 0, 32'h104));
    tbl.push_back(mk("t_sat1", 32'h100, 1, 32'h100, 0, 1, 32'h40, 0, 0, 1, 32'h40));
    tbl.push_back(mk("t_sat2", 32'h100, 1, 32'h100, 0, 1, 32'h40, 0, 0, 1, 32'h40));
    tbl.push_back(mk("t_sat3", 32'h100, 1, 32'h100, 0, 1, 32'h40, 0, 0, 1, 32'h40));
    tbl.push_back(mk("t_sat4", 32'h100, 1, 32'h100, 0, 1, 32'h40, 0, 0, 1, 32'h40));
    tbl.push_back(mk("nt_from3", 32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 1, 32'h40));
    tbl.push_back(idle("held_at3", 32'h100, 1, 32'h40));
    tbl.push_back(idle("alias_miss", 32'h200, 0, 32'h204));
    tbl.push_back(mk("jump_alloc", 32'h200, 1, 32'h200, 1, 1, 32'h80, 0, 0, 0, 32'h204));
    tbl.push_back(idle("jump_hit", 32'h200, 1, 32'h80));
    tbl.push_back(mk("jump_nt", 32'h200, 1, 32'h200, 1, 0, 32'h0, 0, 0, 1, 32'h80));
    tbl.push_back(idle("jump_lowctr", 32'h200, 1, 32'h80));
    tbl.push_back(idle("evicted", 32'h100, 0, 32'h104));
    tbl.push_back(mk("clear_upd", 32'h300, 1, 32'h300, 0, 1, 32'h44, 1, 1, 0, 32'h304));
    tbl.push_back(idle("clr_100", 32'h100, 0, 32'h104));
    tbl.push_back(idle("clr_300", 32'h300, 0, 32'h304));
    tbl.push_back(idle("clr_200", 32'h200, 0, 32'h204));
    tbl.push_back(idle("pc_wrap", 32'hFFFF_FFFC, 0, 32'h0));

    foreach (tbl[k]) begin
      apply(tbl[k]);
      check({tbl[k].name, "_taken"}, pred_taken, tbl[k].et);
      check({tbl[k].name, "_target"}, pred_target, tbl[k].etgt);
      commit();
    end
    check("tbl_cnt", mispred_count, 32'd2);
    check_counts("tbl");

    // Asynchronous reset mid-cycle, with an allocating update pending.
    apply(mk("pre_rst", 32'h40, 1, 32'h40, 0, 1, 32'h10, 1, 0, 0, 32'h44));
    commit();
    apply(mk("rst_pend", 32'h40, 1, 32'h40, 0, 1, 32'h10, 1, 0, 1, 32'h10));
    check("prerst_taken", pred_taken, 1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_cnt", mispred_count, 32'h0);
    check("arst_cnt4", p4_count, 4'h0);
    check("arst_taken", pred_taken, 1'b0);
    check("arst_target", pred_target, 32'h44);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("lost_upd_taken", pred_taken, 1'b0);
    check("lost_upd_cnt", mispred_count, 32'h0);

    // Perf counter saturation on the PERF_W=4 instance.
    for (int n = 0; n < 20; n++) begin
      apply(mk("mp", 32'h500, 1, 32'h500, 0, 0, 32'h0, 1, 0, 0, 32'h504));
      commit();
    end
    apply(idle("mp_done", 32'h500, 0, 32'h504));
    check("sat_cnt4", p4_count, 4'hF);
    check("sat_cnt32", mispred_count, 32'd20);
    check_counts("sat");
    commit();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      v.name = "rnd";
      v.upc  = rand_pc();
      v.pc   = ($urandom_range(0, 3) == 0) ? v.upc : rand_pc();
      v.uv   = ($urandom_range(0, 2) != 0);
      v.uj   = ($urandom_range(0, 3) == 0);
      v.ut   = ($urandom_range(0, 2) != 0);
      v.utgt = $urandom & 32'hFFFF_FFFC;
      v.um   = $urandom_range(0, 1);
      v.clr  = ($urandom_range(0, 49) == 0);
      apply(v);
      model_predict(v.pc, m_tk, m_tg);
      check("rnd_taken", pred_taken, m_tk);
      check("rnd_target", pred_target, m_tg);
      check("rnd_p4_taken", p4_taken, m_tk);
      check_counts("rnd");
      commit();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_branch_predictor

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters, placed in the IF stage beside the PC register.
- Predicts next-fetch PC in the same cycle as instruction fetch, so taken branches/jumps no longer always cost an ID-stage flush.
- Trained by the ID stage when it resolves a branch/jump; also keeps a mispredict performance counter.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB entries; power of two, >= 2. IDX_W = log2(ENTRIES).
- CNT_W, 2, direction counter width; 1..4.
- PERF_W, 32, mispredict counter width.

Ports:
- clk  in  1  main clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous invalidate of all entries (fence.i / debug).
- pc_if  in  XLEN  current fetch PC.
- pred_taken  out  1  redirect fetch to pred_target.
- pred_target  out  XLEN  predicted next PC; pc_if+4 when pred_taken=0.
- upd_valid  in  1  one-cycle pulse per resolved control-flow instruction.
- upd_pc  in  XLEN  PC of resolved instruction.
- upd_is_jump  in  1  1 = unconditional (JAL/JALR), 0 = conditional branch.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual target (valid when upd_taken).
- upd_mispred  in  1  ID found prediction wrong (direction or target).
- mispred_count  out  PERF_W  saturating count of upd_valid & upd_mispred.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target, is_jump, ctr[CNT_W-1:0].
- Lookup is combinational (zero latency, same cycle as the instruction ROM): hit = valid & tag match; pred_taken = hit & (is_jump | ctr[CNT_W-1]); pred_target = pred_taken ? target : pc_if+4 (mod 2^XLEN, wraps).
- Update is registered at the rising clk edge when upd_valid=1:
  - Hit, taken: ctr saturating +1 (stops at 2^CNT_W-1); target and is_jump overwritten.
  - Hit, not taken: ctr saturating -1 (stops at 0); target kept.
  - Miss, taken: allocate/replace entry (direct-mapped): valid=1, tag, target, is_jump, ctr = 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup sees the pre-update contents; the new contents are visible the next cycle.
- clear=1: all valid bits cleared at the edge. clear has priority over a simultaneous upd_valid (that update is dropped). Counters, tags and targets need not be cleared.
- mispred_count: +1 at the edge when upd_valid & upd_mispred; holds at all-ones (no wrap); not affected by clear.
- Reset (rst=0, any time, asynchronous): all valid=0, mispred_count=0. Hence pred_taken=0 and pred_target=pc_if+4 immediately. An update pending during reset is lost.
- No internal stall: the caller must assert upd_valid exactly once per resolved instruction, even if ID is stalled for several cycles.
- Table storage is flops (ENTRIES ≤ 256); no RAM macro is required.

Decomposition:
- Shared package bp_pkg:
  - XLEN default.
  - Entry struct type (valid, tag, target, is_jump, ctr).
  - Counter constants CTR_MAX and CTR_WEAK_T as functions of CNT_W.
- One sub-module, bp_sat_counter: parametrised CNT_W up/down saturating next-state logic, instantiated once per entry.

Test Plan (ENTRIES=64, CNT_W=2):
1. Reset state: rst=0 then 1, pc_if=0x100 -> pred_taken=0, pred_target=0x104, mispred_count=0.
2. Allocation: upd pc=0x100, taken, target=0x40, branch -> next cycle pc_if=0x100 gives pred_taken=1, pred_target=0x40.
3. Counter decay: two not-taken updates on 0x100 -> pred_taken=0 (ctr 2->1->0). Two taken updates -> pred_taken=1 again. Four taken updates -> ctr holds at 3.
4. Aliasing and jumps:
   - Entry held for 0x100; pc_if=0x200 (same index 0, different tag) -> pred_taken=0.
   - upd 0x200 jump taken, target 0x80 -> 0x200 predicts 0x80 and 0x100 now misses.
5. Clear priority: clear=1 together with upd_valid on 0x300 -> next cycle 0x100 and 0x300 both pred_taken=0.
6. Counter saturation and async reset:
   - PERF_W=4: 20 upd_mispred pulses -> mispred_count=15.
   - rst pulsed low mid-clock-cycle -> mispred_count reads 0 before the next clk edge.
